heap_array_unit: RTL and testbench

//  Responder side of the program-to-heap array protocol; test programs (initiators) issue array ops as requests.

---
 rtl/heap_array_unit_pkg.sv | 43 ++++
 rtl/heap_array_unit_if.sv | 33 +++
 rtl/heap_array_unit_freed_array_stack.sv | 46 ++++
 rtl/heap_array_unit.sv | 264 ++++++++++++++++++++++++++
 tb/tb_heap_array_unit.sv | 399 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/heap_array_unit_pkg.sv
// ============================================================================
// Module : heap_array_pkg
// Brief  : Shared op/state encodings and sizing helpers for the heap array unit
// Rev    : 1.0
// ============================================================================
`default_nettype none

package heap_array_pkg;

    typedef enum logic [2:0] {
        ALLOC = 3'd0,
        FREE  = 3'd1,
        PUSH  = 3'd2,
        POP   = 3'd3,
        GET   = 3'd4,
        PUT   = 3'd5,
        SIZE  = 3'd6
    } heap_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int MEW_DEFAULT      = 12;
    localparam int N_AREA_DEFAULT   = 4;
    localparam int N_ARRAYS_DEFAULT = 4;

    function automatic int heap_depth(input int n_arrays, input int n_area);
        return n_arrays * n_area;
    endfunction

    // Index width that never collapses to zero for single-entry tables
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int HEAP_DEPTH = heap_depth(N_ARRAYS_DEFAULT, N_AREA_DEFAULT);

endpackage

`default_nettype wire

// File: rtl/heap_array_unit_if.sv
// ============================================================================
// Module : heap_array_if
// Brief  : Request/response valid-ready bundle between initiator and unit
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface heap_array_if #(
    parameter int MEW = 12
);
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [MEW-1:0] req_array;
    logic [MEW-1:0] req_index;
    logic [MEW-1:0] req_data;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [MEW-1:0] rsp_data;
    logic           rsp_error;

    modport master (
        output req_valid, req_op, req_array, req_index, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_error
    );

    modport slave (
        input  req_valid, req_op, req_array, req_index, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_error
    );
endinterface

`default_nettype wire

// File: rtl/heap_array_unit_freed_array_stack.sv
// ============================================================================
// Module : freed_array_stack
// Brief  : LIFO of freed array ids; pushes beyond DEPTH are dropped
// Rev    : 1.0
// ============================================================================
`default_nettype none

module freed_array_stack
    import heap_array_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 12
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             i_push,
    input  wire logic             i_pop,
    input  wire logic [WIDTH-1:0] i_data,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [WIDTH-1:0]      o_top
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = idx_w(DEPTH);

    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_push && !o_full) begin
            r_mem[IW'(r_count)] <= i_data;
            r_count             <= r_count + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_top   = r_mem[IW'(r_count - CW'(1))];

endmodule

`default_nettype wire

// File: rtl/heap_array_unit.sv
// ============================================================================
// Module : heap_array_unit
// Brief  : Responder servicing alloc/free/push/pop/get/put/size on heap arrays.
//          Define HEAP_ARRAY_STATS_EN to add peak_allocs/op_count outputs.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module heap_array_unit
    import heap_array_pkg::*;
#(
    parameter int MEMORY_ELEMENT_WIDTH = MEW_DEFAULT,
    parameter int N_AREA               = N_AREA_DEFAULT,
    parameter int N_ARRAYS             = N_ARRAYS_DEFAULT
) (
    input  wire logic   clock,
    input  wire logic   reset,
    heap_array_if.slave bus
`ifdef HEAP_ARRAY_STATS_EN
    ,
    output logic [MEMORY_ELEMENT_WIDTH-1:0] peak_allocs,
    output logic [31:0]                     op_count
`endif
);
    localparam int MEW   = MEMORY_ELEMENT_WIDTH;
    localparam int DEPTH = heap_depth(N_ARRAYS, N_AREA);
    localparam int AIW   = idx_w(N_ARRAYS);
    localparam int EIW   = idx_w(N_AREA);
    localparam int HW    = idx_w(DEPTH);

    state_t         r_state;
    logic           r_req_ready;
    logic           r_rsp_valid;
    logic           r_rsp_error;
    logic [MEW-1:0] r_rsp_data;
    logic [2:0]     r_op;
    logic [MEW-1:0] r_array;
    logic [MEW-1:0] r_index;
    logic [MEW-1:0] r_data;
    logic [MEW-1:0] r_allocs;
    logic [MEW-1:0] r_size [N_ARRAYS];
    logic [MEW-1:0] r_heap [DEPTH];

    logic           w_exec;
    logic           w_arr_ok;
    logic           w_idx_ok;
    logic [AIW-1:0] w_aidx;
    logic [MEW-1:0] w_cur_size;
    logic [EIW-1:0] w_eidx;
    logic [HW-1:0]  w_addr;
    logic [MEW-1:0] w_heap_rd;
    logic           w_err;
    logic [MEW-1:0] w_rdata;
    logic           w_heap_we;
    logic           w_size_we;
    logic [AIW-1:0] w_size_idx;
    logic [MEW-1:0] w_size_val;
    logic           w_alloc_inc;
    logic           w_st_push;
    logic           w_st_pop;
    logic           w_st_empty;
    logic           w_st_full;
    logic [MEW-1:0] w_st_top;

    assign w_exec     = (r_state == EXEC);
    assign w_arr_ok   = (r_array < MEW'(N_ARRAYS));
    assign w_idx_ok   = (r_index < MEW'(N_AREA));
    assign w_aidx     = r_array[AIW-1:0];
    assign w_cur_size = r_size[w_aidx];
    assign w_addr     = HW'(w_aidx) * HW'(N_AREA) + HW'(w_eidx);
    assign w_heap_rd  = r_heap[w_addr];

    // Decode the latched request; effects are committed only while in EXEC
    always_comb begin
        w_err       = 1'b1;
        w_rdata     = '0;
        w_eidx      = '0;
        w_heap_we   = 1'b0;
        w_size_we   = 1'b0;
        w_size_idx  = w_aidx;
        w_size_val  = '0;
        w_alloc_inc = 1'b0;
        w_st_push   = 1'b0;
        w_st_pop    = 1'b0;
        case (r_op)
            ALLOC: begin
                if (!w_st_empty) begin
                    w_err      = 1'b0;
                    w_rdata    = w_st_top;
                    w_st_pop   = 1'b1;
                    w_size_we  = 1'b1;
                    w_size_idx = w_st_top[AIW-1:0];
                end else if (r_allocs < MEW'(N_ARRAYS)) begin
                    w_err       = 1'b0;
                    w_rdata     = r_allocs;
                    w_alloc_inc = 1'b1;
                    w_size_we   = 1'b1;
                    w_size_idx  = r_allocs[AIW-1:0];
                end
            end
            FREE: begin
                if (w_arr_ok) begin
                    w_err     = 1'b0;
                    w_st_push = !w_st_full;
                    w_size_we = 1'b1;
                end
            end
            PUSH: begin
                if (w_arr_ok && (w_cur_size < MEW'(N_AREA))) begin
                    w_err      = 1'b0;
                    w_eidx     = w_cur_size[EIW-1:0];
                    w_heap_we  = 1'b1;
                    w_size_we  = 1'b1;
                    w_size_val = w_cur_size + MEW'(1);
                end
            end
            POP: begin
                if (w_arr_ok && (w_cur_size != '0)) begin
                    w_err      = 1'b0;
                    w_eidx     = EIW'(w_cur_size - MEW'(1));
                    w_rdata    = w_heap_rd;
                    w_size_we  = 1'b1;
                    w_size_val = w_cur_size - MEW'(1);
                end
            end
            GET: begin
                if (w_arr_ok && w_idx_ok) begin
                    w_err   = 1'b0;
                    w_eidx  = r_index[EIW-1:0];
                    w_rdata = w_heap_rd;
                end
            end
            PUT: begin
                if (w_arr_ok && w_idx_ok) begin
                    w_err      = 1'b0;
                    w_eidx     = r_index[EIW-1:0];
                    w_heap_we  = 1'b1;
                    w_size_we  = 1'b1;
                    w_size_val = (r_index >= w_cur_size) ? (r_index + MEW'(1)) : w_cur_size;
                end
            end
            SIZE: begin
                if (w_arr_ok) begin
                    w_err   = 1'b0;
                    w_rdata = w_cur_size;
                end
            end
            default: ;
        endcase
    end

    freed_array_stack #(
        .DEPTH (N_ARRAYS),
        .WIDTH (MEW)
    ) u_freed_stack (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_exec && w_st_push),
        .i_pop   (w_exec && w_st_pop),
        .i_data  (r_array),
        .o_empty (w_st_empty),
        .o_full  (w_st_full),
        .o_top   (w_st_top)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_req_ready <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_error <= 1'b0;
            r_rsp_data  <= '0;
            r_op        <= '0;
            r_array     <= '0;
            r_index     <= '0;
            r_data      <= '0;
            r_allocs    <= '0;
            for (int i = 0; i < N_ARRAYS; i++) begin
                r_size[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (r_req_ready && bus.req_valid) begin
                        r_op        <= bus.req_op;
                        r_array     <= bus.req_array;
                        r_index     <= bus.req_index;
                        r_data      <= bus.req_data;
                        r_req_ready <= 1'b0;
                        r_state     <= EXEC;
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= w_rdata;
                    r_rsp_error <= w_err;
                    r_rsp_valid <= 1'b1;
                    if (w_size_we) begin
                        r_size[w_size_idx] <= w_size_val;
                    end
                    if (w_alloc_inc) begin
                        r_allocs <= r_allocs + MEW'(1);
                    end
                    r_state <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Heap is deliberately left out of reset so it can map onto plain RAM
    always_ff @(posedge clock) begin
        if (reset && w_exec && w_heap_we) begin
            r_heap[w_addr] <= r_data;
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_error = r_rsp_error;

`ifdef HEAP_ARRAY_STATS_EN
    logic [MEW-1:0] r_live;
    logic [MEW-1:0] r_peak;
    logic [31:0]    r_op_count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_live     <= '0;
            r_peak     <= '0;
            r_op_count <= '0;
        end else begin
            if (w_exec && !w_err) begin
                if (r_op == ALLOC) begin
                    r_live <= r_live + MEW'(1);
                    if ((r_live + MEW'(1)) > r_peak) begin
                        r_peak <= r_live + MEW'(1);
                    end
                end else if ((r_op == FREE) && w_st_push) begin
                    r_live <= r_live - MEW'(1);
                end
            end
            if ((r_state == RESP) && bus.rsp_ready) begin
                r_op_count <= r_op_count + 32'd1;
            end
        end
    end

    assign peak_allocs = r_peak;
    assign op_count    = r_op_count;
`endif

endmodule

`default_nettype wire

// File: tb/tb_heap_array_unit.sv
// ============================================================================
// Module : tb_heap_array_unit
// Brief  : Scoreboard bench for heap_array_unit request/response behaviour
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_heap_array_unit;
    import heap_array_pkg::*;

    typedef struct packed {
        logic [2:0]  op;
        logic [11:0] arr;
        logic [11:0] idx;
        logic [11:0] data;
        logic        err;
        logic [11:0] exp;
    } step_t;

    typedef struct packed {
        logic        err;
        logic [11:0] data;
    } rsp_t;

    logic clock;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    rsp_t exp_q[$];

    heap_array_if #(.MEW(12)) bus ();

`ifdef HEAP_ARRAY_STATS_EN
    logic [11:0] peak_allocs;
    logic [31:0] op_count;
`endif

    heap_array_unit #(
        .MEMORY_ELEMENT_WIDTH (12),
        .N_AREA               (4),
        .N_ARRAYS             (4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus)
`ifdef HEAP_ARRAY_STATS_EN
        ,
        .peak_allocs (peak_allocs),
        .op_count    (op_count)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    function automatic step_t mk(input logic [2:0] op, input int arr, input int idx,
                                 input int data, input logic err, input int exp);
        step_t s;
        s.op   = op;
        s.arr  = 12'(arr);
        s.idx  = 12'(idx);
        s.data = 12'(data);
        s.err  = err;
        s.exp  = 12'(exp);
        return s;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_op    = 3'd0;
        bus.req_array = '0;
        bus.req_index = '0;
        bus.req_data  = '0;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic drive_req(input step_t s);
        bus.req_op    = s.op;
        bus.req_array = s.arr;
        bus.req_index = s.idx;
        bus.req_data  = s.data;
        bus.req_valid = 1'b1;
    endtask

    // Issue one request and wait for its response; lat counts edges from accept
    task automatic xact(input step_t s, output rsp_t got, output int lat);
        int n;
        got = '0;
        lat = -1;
        drive_req(s);
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (bus.req_ready !== 1'b1) begin
            checks++; failures++;
            $display("FAIL req_ready_timeout got=%b want=1", bus.req_ready);
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        if (bus.rsp_valid !== 1'b1) begin
            checks++; failures++;
            $display("FAIL rsp_valid_timeout got=%b want=1", bus.rsp_valid);
            return;
        end
        lat = n + 1;
        got = {bus.rsp_error, bus.rsp_data};
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        step_t s;
        rsp_t  got, exp;
        int    lat;
        idle_inputs();
        reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (bus.req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got=%b want=0", bus.req_ready); end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        checks++;
        if ({bus.rsp_error, bus.rsp_data} !== 13'd0) begin
            failures++; $display("FAIL reset_rsp got err=%b data=%0d want 0/0", bus.rsp_error, bus.rsp_data);
        end
        reset = 1'b1;
        @(posedge clock); #1;
        checks++;
        if (bus.req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_req_ready got=%b want=1", bus.req_ready); end
`ifdef HEAP_ARRAY_STATS_EN
        checks++;
        if (peak_allocs !== 12'd0 || op_count !== 32'd0) begin
            failures++; $display("FAIL reset_stats got peak=%0d ops=%0d want 0/0", peak_allocs, op_count);
        end
`endif
        s = mk(SIZE, 3, 0, 0, 1'b0, 0);
        exp_q.push_back({s.err, s.exp});
        xact(s, got, lat);
        exp = exp_q.pop_front();
        checks++;
        if (got !== exp) begin
            failures++; $display("FAIL reset_size got err=%b data=%0d want err=%b data=%0d", got.err, got.data, exp.err, exp.data);
        end
    endtask

    task automatic test_push_program();
        step_t s[$];
        rsp_t  got, exp;
        int    lat;
        do_reset();
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, 0));
        s.push_back(mk(PUSH,  0, 0, 1, 1'b0, 0));
        s.push_back(mk(PUSH,  0, 0, 2, 1'b0, 0));
        s.push_back(mk(SIZE,  0, 0, 0, 1'b0, 2));
        s.push_back(mk(GET,   0, 0, 0, 1'b0, 1));
        s.push_back(mk(GET,   0, 1, 0, 1'b0, 2));
        foreach (s[i]) begin
            exp_q.push_back({s[i].err, s[i].exp});
            xact(s[i], got, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL push_program step %0d got err=%b data=%0d want err=%b data=%0d", i, got.err, got.data, exp.err, exp.data);
            end
        end
    endtask

    task automatic test_alloc_free();
        step_t s[$];
        rsp_t  got, exp;
        int    lat;
        do_reset();
        for (int k = 0; k < 4; k++) s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, k));
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b1, 0));
        s.push_back(mk(FREE,  2, 0, 0, 1'b0, 0));
        s.push_back(mk(FREE,  1, 0, 0, 1'b0, 0));
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, 1));
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, 2));
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b1, 0));
        s.push_back(mk(FREE,  4, 0, 0, 1'b1, 0));
        s.push_back(mk(SIZE,  4, 0, 0, 1'b1, 0));
        foreach (s[i]) begin
            exp_q.push_back({s[i].err, s[i].exp});
            xact(s[i], got, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL alloc_free step %0d got err=%b data=%0d want err=%b data=%0d", i, got.err, got.data, exp.err, exp.data);
            end
        end
    endtask

    task automatic test_push_pop();
        step_t s[$];
        rsp_t  got, exp;
        int    lat;
        do_reset();
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, 0));
        for (int k = 1; k <= 4; k++) s.push_back(mk(PUSH, 0, 0, k, 1'b0, 0));
        s.push_back(mk(PUSH, 0, 0, 5, 1'b1, 0));
        s.push_back(mk(SIZE, 0, 0, 0, 1'b0, 4));
        for (int k = 4; k >= 1; k--) s.push_back(mk(POP, 0, 0, 0, 1'b0, k));
        s.push_back(mk(POP,  0, 0, 0, 1'b1, 0));
        s.push_back(mk(SIZE, 0, 0, 0, 1'b0, 0));
        foreach (s[i]) begin
            exp_q.push_back({s[i].err, s[i].exp});
            xact(s[i], got, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL push_pop step %0d got err=%b data=%0d want err=%b data=%0d", i, got.err, got.data, exp.err, exp.data);
            end
        end
    endtask

    task automatic test_put_get();
        step_t s[$];
        rsp_t  got, exp;
        int    lat;
        do_reset();
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, 0));
        s.push_back(mk(PUT,   0, 3, 9, 1'b0, 0));
        s.push_back(mk(SIZE,  0, 0, 0, 1'b0, 4));
        s.push_back(mk(GET,   0, 3, 0, 1'b0, 9));
        s.push_back(mk(GET,   0, 4, 0, 1'b1, 0));
        s.push_back(mk(PUT,   0, 1, 7, 1'b0, 0));
        s.push_back(mk(SIZE,  0, 0, 0, 1'b0, 4));
        s.push_back(mk(GET,   0, 1, 0, 1'b0, 7));
        s.push_back(mk(PUT,   0, 4, 5, 1'b1, 0));
        s.push_back(mk(3'd7,  0, 0, 0, 1'b1, 0));
        foreach (s[i]) begin
            exp_q.push_back({s[i].err, s[i].exp});
            xact(s[i], got, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL put_get step %0d got err=%b data=%0d want err=%b data=%0d", i, got.err, got.data, exp.err, exp.data);
            end
        end
    endtask

    task automatic test_hold();
        rsp_t got, exp;
        int   lat, n;
        bit   bad;
        do_reset();
        xact(mk(ALLOC, 0, 0, 0, 1'b0, 0), got, lat);
        xact(mk(PUSH, 0, 0, 5, 1'b0, 0), got, lat);
        exp_q.push_back({1'b0, 12'd1});
        drive_req(mk(SIZE, 0, 0, 0, 1'b0, 1));
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        n = 0;
        while (bus.rsp_valid !== 1'b1 && n < 20) begin
            @(posedge clock); #1; n++;
        end
        checks++;
        if (n != 1) begin failures++; $display("FAIL hold_latency got=%0d edges want=1", n); end
        exp = exp_q.pop_front();
        bad = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid !== 1'b1 || {bus.rsp_error, bus.rsp_data} !== exp || bus.req_ready !== 1'b0) bad = 1'b1;
            @(posedge clock); #1;
        end
        checks++;
        if (bad || bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp.data) begin
            failures++; $display("FAIL hold_stable got valid=%b data=%0d ready=%b want 1/%0d/0", bus.rsp_valid, bus.rsp_data, bus.req_ready, exp.data);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clock); #1;
        bus.rsp_ready = 1'b0;
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
            failures++; $display("FAIL hold_release got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_back_to_back();
        int acc[$];
        do_reset();
        bus.rsp_ready = 1'b1;
        drive_req(mk(SIZE, 0, 0, 0, 1'b0, 0));
        for (int c = 0; c < 12; c++) begin
            if (bus.req_ready === 1'b1) acc.push_back(c);
            @(posedge clock); #1;
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        checks++;
        if (acc.size() < 3) begin
            failures++; $display("FAIL b2b_accepts got=%0d want>=3", acc.size());
        end else if (acc[1] - acc[0] != 3 || acc[2] - acc[1] != 3) begin
            failures++; $display("FAIL b2b_spacing got=%0d,%0d want=3,3", acc[1] - acc[0], acc[2] - acc[1]);
        end
    endtask

    task automatic test_reset_mid();
        step_t s[$];
        rsp_t  got, exp;
        int    lat;
        bit    seen;
        do_reset();
        xact(mk(ALLOC, 0, 0, 0, 1'b0, 0), got, lat);
        xact(mk(PUSH, 0, 0, 3, 1'b0, 0), got, lat);
        drive_req(mk(PUSH, 0, 0, 4, 1'b0, 0));
        @(posedge clock); #1;
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
            @(posedge clock); #1;
        end
        bus.rsp_ready = 1'b0;
        checks++;
        if (seen) begin failures++; $display("FAIL reset_mid_rsp got=1 want=0"); end
        s.push_back(mk(SIZE,  0, 0, 0, 1'b0, 0));
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, 0));
        foreach (s[i]) begin
            exp_q.push_back({s[i].err, s[i].exp});
            xact(s[i], got, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL reset_mid step %0d got err=%b data=%0d want err=%b data=%0d", i, got.err, got.data, exp.err, exp.data);
            end
        end
    endtask

`ifdef HEAP_ARRAY_STATS_EN
    task automatic test_stats();
        step_t s[$];
        rsp_t  got, exp;
        int    lat;
        do_reset();
        for (int k = 0; k < 3; k++) s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, k));
        s.push_back(mk(FREE,  1, 0, 0, 1'b0, 0));
        s.push_back(mk(ALLOC, 0, 0, 0, 1'b0, 1));
        foreach (s[i]) begin
            exp_q.push_back({s[i].err, s[i].exp});
            xact(s[i], got, lat);
            exp = exp_q.pop_front();
            checks++;
            if (got !== exp) begin
                failures++; $display("FAIL stats step %0d got err=%b data=%0d want err=%b data=%0d", i, got.err, got.data, exp.err, exp.data);
            end
        end
        checks++;
        if (peak_allocs !== 12'd3) begin failures++; $display("FAIL stats_peak got=%0d want=3", peak_allocs); end
        checks++;
        if (op_count !== 32'd5) begin failures++; $display("FAIL stats_ops got=%0d want=5", op_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_push_program();
        test_alloc_free();
        test_push_pop();
        test_put_get();
        test_hold();
        test_back_to_back();
        test_reset_mid();
`ifdef HEAP_ARRAY_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
